// File: rtl/bpsk_rx_pkg.sv
// Shared constants for the BPSK receive / BER block: FSM encodings and
// default geometry of the decimator, alignment search and windows.
package bpsk_rx_pkg;

  localparam int DEF_OS       = 4;
  localparam int DEF_NB_PHASE = 2;
  localparam int DEF_NB_DELAY = 9;
  localparam int DEF_WIN_LEN  = 511;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCK   = 1'b1;

endpackage

// File: rtl/bpsk_rx_sat_counter.sv
// Saturating accumulator: adds i_inc on each enabled cycle and sticks at
// all-ones instead of wrapping. i_clear has priority.
module bpsk_rx_sat_counter #(
  parameter int NB_CNT = 64
) (
  input  logic              clock,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic              i_inc,
  output logic [NB_CNT-1:0] o_count
);

  logic [NB_CNT-1:0] count_q, count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (i_enable && i_inc && (count_q != '1)) begin
      count_d = count_q + NB_CNT'(1);
    end
  end

  // Count register with clear.
  always_ff @(posedge clock) begin
    if (i_clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/bpsk_rx_ber.sv
// BPSK receiver with BER measurement: decimates the oversampled stream at a
// selectable phase, slices the sign, searches the link delay against the PRBS
// reference, then counts bits and errors while locked.
// Optional feature macro: BPSK_RX_RELOCK_EN (error-window relock while in LOCK).
//
// state     | meaning
// ST_SEARCH | trying delay_q; a window with zero errors locks, else delay_q+1
// ST_LOCK   | delay fixed; bit/error counters accumulate
module bpsk_rx_ber
  import bpsk_rx_pkg::*;
#(
  parameter int NB_INPUT = 8,
  parameter int OS       = DEF_OS,
  parameter int NB_PHASE = DEF_NB_PHASE,
  parameter int NB_DELAY = DEF_NB_DELAY,
  parameter int WIN_LEN  = DEF_WIN_LEN,
  parameter int NB_CNT   = 64,
  parameter int ERR_THR  = 16
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_INPUT-1:0] i_sample,
  input  logic [NB_PHASE-1:0] i_phase_sel,
  input  logic                i_ref_bit,
  input  logic                i_ref_valid,
  input  logic                i_ber_clear,
  output logic                o_bit,
  output logic                o_bit_valid,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count
);

  localparam int REF_LEN = 2**NB_DELAY;
  localparam int NB_WIN  = $clog2(WIN_LEN + 1);
`ifdef BPSK_RX_RELOCK_EN
  localparam logic RELOCK_EN = 1'b1;
`else
  localparam logic RELOCK_EN = 1'b0;
`endif

  logic [NB_PHASE-1:0] phase_cnt_q, phase_cnt_d;
  logic [REF_LEN-1:0]  ref_sr_q, ref_sr_d;
  logic                bit_q, bit_d;
  logic                valid_q, valid_d;
  logic [0:0]          state_q, state_d;
  logic [NB_DELAY-1:0] delay_q, delay_d;
  logic [NB_WIN-1:0]   win_sym_q, win_sym_d;
  logic [NB_WIN-1:0]   win_err_q, win_err_d;

  logic              decide, slice, cmp_bit, err;
  logic [NB_WIN-1:0] win_err_sum;
  logic              win_end, lock_entry, relock;
  logic              cnt_clear, cnt_enable;
  // Only the sign of the sample carries the decision.
  logic              sample_lsbs_unused;

  assign sample_lsbs_unused = ^i_sample[NB_INPUT-2:0];

  assign decide      = i_enable && (phase_cnt_q == i_phase_sel);
  assign slice       = i_sample[NB_INPUT-1];
  assign cmp_bit     = ref_sr_q[delay_q];
  assign err         = slice ^ cmp_bit;
  assign win_err_sum = win_err_q + NB_WIN'(err);
  assign win_end     = decide && (win_sym_q == NB_WIN'(WIN_LEN - 1));
  assign lock_entry  = (state_q == ST_SEARCH) && win_end && (win_err_sum == '0);
  assign relock      = RELOCK_EN && (state_q == ST_LOCK) && win_end &&
                       (win_err_sum > NB_WIN'(ERR_THR));

  // Datapath next state: phase counter, reference history, sliced bit.
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    ref_sr_d    = ref_sr_q;
    bit_d       = bit_q;
    valid_d     = decide;
    if (i_enable) begin
      phase_cnt_d = (phase_cnt_q == NB_PHASE'(OS - 1)) ? '0 : phase_cnt_q + NB_PHASE'(1);
      if (i_ref_valid) begin
        ref_sr_d = {ref_sr_q[REF_LEN-2:0], i_ref_bit};
      end
    end
    if (decide) begin
      bit_d = slice;
    end
  end

  // Datapath registers; a BER clear leaves these running.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase_cnt_q <= '0;
      ref_sr_q    <= '0;
      bit_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      ref_sr_q    <= ref_sr_d;
      bit_q       <= bit_d;
      valid_q     <= valid_d;
    end
  end

  // FSM next state: window accounting and delay stepping per decision.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    win_sym_d = win_sym_q;
    win_err_d = win_err_q;
    if (decide) begin
      if (win_end) begin
        win_sym_d = '0;
        win_err_d = '0;
        if (state_q == ST_SEARCH) begin
          if (lock_entry) begin
            state_d = ST_LOCK;
          end else begin
            delay_d = delay_q + NB_DELAY'(1);
          end
        end else if (relock) begin
          state_d = ST_SEARCH;
          delay_d = delay_q + NB_DELAY'(1);
        end
      end else begin
        win_sym_d = win_sym_q + NB_WIN'(1);
        win_err_d = win_err_sum;
      end
    end
  end

  // FSM registers; reset or BER clear restarts the search at delay 0.
  always_ff @(posedge clock) begin
    if (i_reset || i_ber_clear) begin
      state_q   <= ST_SEARCH;
      delay_q   <= '0;
      win_sym_q <= '0;
      win_err_q <= '0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      win_sym_q <= win_sym_d;
      win_err_q <= win_err_d;
    end
  end

  // Counters restart on every lock entry so each lock measures afresh.
  assign cnt_clear  = i_reset || i_ber_clear || lock_entry;
  assign cnt_enable = decide && (state_q == ST_LOCK);

  bpsk_rx_sat_counter #(.NB_CNT(NB_CNT)) u_bit_cnt (
    .clock    (clock),
    .i_clear  (cnt_clear),
    .i_enable (cnt_enable),
    .i_inc    (1'b1),
    .o_count  (o_bit_count)
  );

  bpsk_rx_sat_counter #(.NB_CNT(NB_CNT)) u_err_cnt (
    .clock    (clock),
    .i_clear  (cnt_clear),
    .i_enable (cnt_enable),
    .i_inc    (err),
    .o_count  (o_err_count)
  );

  assign o_bit       = bit_q;
  assign o_bit_valid = valid_q;
  assign o_locked    = (state_q == ST_LOCK);
  assign o_delay     = delay_q;

endmodule

// File: tb/tb_bpsk_rx_ber.sv
// Bench for bpsk_rx_ber. A short window (31 symbols) with a 64-deep delay range
// keeps the 38-window search short; PRBS9 never repeats inside such a window,
// so wrong delays can never look error-free. A second instance with 4-bit
// counters exposes saturation. Relock expectations follow BPSK_RX_RELOCK_EN.
module tb_bpsk_rx_ber;

  localparam int NB_INPUT = 8;
  localparam int OS       = 4;
  localparam int NB_PHASE = 2;
  localparam int NB_DELAY = 6;
  localparam int WIN_LEN  = 31;
  localparam int NB_CNT   = 64;
  localparam int ERR_THR  = 4;
  localparam int MAXSYM   = 16384;

  logic                clock = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_enable = 1'b0;
  logic [NB_INPUT-1:0] i_sample = '0;
  logic [NB_PHASE-1:0] i_phase_sel = '0;
  logic                i_ref_bit = 1'b0;
  logic                i_ref_valid = 1'b0;
  logic                i_ber_clear = 1'b0;
  logic                o_bit, o_bit_valid, o_locked;
  logic [NB_DELAY-1:0] o_delay;
  logic [NB_CNT-1:0]   o_bit_count, o_err_count;
  logic                s_bit, s_bit_valid, s_locked;
  logic [NB_DELAY-1:0] s_delay;
  logic [3:0]          s_bit_count, s_err_count;

  int checks = 0;
  int errors = 0;
  bit tx [0:MAXSYM-1];
  int n_sym = 0;
  int link_delay = 0;
  int en_cnt = 0;
  int n_valid = 0;
  bit obs_q[$];
  bit exp_q[$];
  logic [8:0] lfsr = 9'h1ff;

  always #5 clock = ~clock;

  bpsk_rx_ber #(.NB_INPUT(NB_INPUT), .OS(OS), .NB_PHASE(NB_PHASE), .NB_DELAY(NB_DELAY),
                .WIN_LEN(WIN_LEN), .NB_CNT(NB_CNT), .ERR_THR(ERR_THR)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sample(i_sample),
    .i_phase_sel(i_phase_sel), .i_ref_bit(i_ref_bit), .i_ref_valid(i_ref_valid),
    .i_ber_clear(i_ber_clear), .o_bit(o_bit), .o_bit_valid(o_bit_valid),
    .o_locked(o_locked), .o_delay(o_delay), .o_bit_count(o_bit_count),
    .o_err_count(o_err_count));

  bpsk_rx_ber #(.NB_INPUT(NB_INPUT), .OS(OS), .NB_PHASE(NB_PHASE), .NB_DELAY(NB_DELAY),
                .WIN_LEN(WIN_LEN), .NB_CNT(4), .ERR_THR(ERR_THR)) dut_s (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sample(i_sample),
    .i_phase_sel(i_phase_sel), .i_ref_bit(i_ref_bit), .i_ref_valid(i_ref_valid),
    .i_ber_clear(i_ber_clear), .o_bit(s_bit), .o_bit_valid(s_bit_valid),
    .o_locked(s_locked), .o_delay(s_delay), .o_bit_count(s_bit_count),
    .o_err_count(s_err_count));

  task automatic tick();
    @(posedge clock);
    #1;
    if (o_bit_valid) begin
      n_valid++;
      obs_q.push_back(o_bit);
    end
  endtask

  task automatic prbs_next(output bit b);
    b = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], b};
  endtask

  function automatic logic [7:0] sample_for(input bit b);
    return b ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
  endfunction

  task automatic idle_cycle();
    i_enable    = 1'b0;
    i_ber_clear = 1'b0;
    i_sample    = 8'($urandom);
    i_ref_valid = 1'($urandom);
    i_ref_bit   = 1'($urandom);
    tick();
  endtask

  // Enabled filler cycles until the next enabled cycle is the decision phase.
  task automatic align();
    while ((en_cnt % OS) != int'(i_phase_sel)) begin
      i_enable = 1'b1; i_ber_clear = 1'b0; i_ref_valid = 1'b0;
      i_sample = 8'($urandom);
      tick();
      en_cnt++;
    end
  endtask

  // One symbol slot: the reference bit enters on the decision cycle; the
  // transmit pipeline adds one symbol, so the received symbol is tx[n-1-delay].
  task automatic send_symbol(input bit flip, input bit gaps, output bit rx_o);
    int idx;
    bit rx, tb_bit;
    align();
    prbs_next(tb_bit);
    tx[n_sym] = tb_bit;
    idx = n_sym - 1 - link_delay;
    rx = (idx >= 0) ? tx[idx] : 1'b0;
    rx_o = rx ^ flip;
    exp_q.push_back(rx_o);
    for (int k = 0; k < OS; k++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idle_cycle();
      end
      i_enable    = 1'b1;
      i_ber_clear = 1'b0;
      i_ref_valid = (k == 0);
      i_ref_bit   = (k == 0) ? tx[n_sym] : 1'($urandom);
      i_sample    = (k == 0) ? sample_for(rx_o) : 8'($urandom);
      tick();
      en_cnt++;
    end
    n_sym++;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_enable = 1'($urandom); i_sample = 8'($urandom); i_phase_sel = 2'($urandom);
      i_ref_bit = 1'($urandom); i_ref_valid = 1'($urandom); i_ber_clear = 1'($urandom);
      tick();
    end
    en_cnt = 0;
    checks++; if (o_bit !== 1'b0) begin errors++; $display("FAIL reset_bit got %0d want 0", o_bit); end
    checks++; if (o_bit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", o_bit_valid); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0d want 0", o_locked); end
    checks++; if (o_delay !== '0) begin errors++; $display("FAIL reset_delay got %0d want 0", o_delay); end
    checks++; if (o_bit_count !== '0) begin errors++; $display("FAIL reset_bitcnt got %0d want 0", o_bit_count); end
    checks++; if (o_err_count !== '0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", o_err_count); end
  endtask

  task automatic test_phase();
    logic [7:0] pat [4] = '{8'h40, 8'h40, 8'hC0, 8'h40};
    logic [7:0] smp;
    bit exp_v;
    int bad_v = 0, bad_b = 0;
    i_reset = 1'b0; i_ber_clear = 1'b0; i_ref_valid = 1'b0;
    i_phase_sel = 2'd2;
    for (int k = 0; k < 40; k++) begin
      i_enable = 1'b1; i_sample = pat[k % 4];
      exp_v = ((k % 4) == 2);
      tick();
      en_cnt++;
      if (o_bit_valid !== exp_v) bad_v++;
      if (exp_v && o_bit !== 1'b1) bad_b++;
    end
    checks++; if (bad_v != 0) begin errors++; $display("FAIL phase2_valid got %0d bad strobes want 0", bad_v); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL phase2_bit got %0d bad bits want 0", bad_b); end
    i_phase_sel = 2'd3;
    for (int k = 0; k < 4; k++) begin i_enable = 1'b1; i_sample = 8'($urandom); tick(); en_cnt++; end
    bad_v = 0; bad_b = 0;
    for (int k = 0; k < 60; k++) begin
      i_enable = 1'($urandom); smp = 8'($urandom); i_sample = smp;
      exp_v = i_enable && ((en_cnt % OS) == 3);
      tick();
      if (i_enable) en_cnt++;
      if (o_bit_valid !== exp_v) bad_v++;
      if (exp_v && o_bit !== smp[7]) bad_b++;
    end
    checks++; if (bad_v != 0) begin errors++; $display("FAIL phase3_gap_valid got %0d bad strobes want 0", bad_v); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL phase3_gap_bit got %0d bad bits want 0", bad_b); end
  endtask

  task automatic test_lock(input bit gaps);
    int start, v0, mism;
    bit got, rb;
    start = n_sym; got = 1'b0; v0 = n_valid;
    obs_q.delete(); exp_q.delete();
    while (!got && (n_sym - start) < 45 * WIN_LEN) begin
      send_symbol(1'b0, gaps, rb);
      if (o_locked) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL lock_reached got 0 want 1 (gaps=%0d)", gaps); end
    checks++; if ((n_sym - start) != 38 * WIN_LEN) begin errors++;
      $display("FAIL lock_symbols got %0d want %0d (gaps=%0d)", n_sym - start, 38 * WIN_LEN, gaps); end
    checks++; if (o_delay !== NB_DELAY'(37)) begin errors++; $display("FAIL lock_delay got %0d want 37 (gaps=%0d)", o_delay, gaps); end
    checks++; if (o_bit_count !== '0 || o_err_count !== '0) begin errors++;
      $display("FAIL lock_cnt_start got %0d/%0d want 0/0", o_bit_count, o_err_count); end
    checks++; if ((n_valid - v0) != (n_sym - start)) begin errors++;
      $display("FAIL lock_strobes got %0d want %0d (gaps=%0d)", n_valid - v0, n_sym - start, gaps); end
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] != exp_q[i]) mism++;
    checks++; if (mism != 0 || obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL lock_bits got %0d mismatches (%0d of %0d) want 0", mism, obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_ber();
    bit rb;
    int v0 = n_valid;
    for (int i = 0; i < 10000; i++) send_symbol((i % 100) == 99, 1'b0, rb);
    checks++; if (o_bit_count !== 64'd10000) begin errors++; $display("FAIL ber_bitcnt got %0d want 10000", o_bit_count); end
    checks++; if (o_err_count !== 64'd100) begin errors++; $display("FAIL ber_errcnt got %0d want 100", o_err_count); end
    checks++; if (o_locked !== 1'b1 || o_delay !== NB_DELAY'(37)) begin errors++;
      $display("FAIL ber_lock got %0d@%0d want 1@37", o_locked, o_delay); end
    checks++; if ((n_valid - v0) != 10000) begin errors++; $display("FAIL ber_strobes got %0d want 10000", n_valid - v0); end
    checks++; if (s_bit_count !== 4'hF || s_err_count !== 4'hF) begin errors++;
      $display("FAIL sat_counts got %0d/%0d want 15/15", s_bit_count, s_err_count); end
  endtask

  task automatic test_enable_gaps();
    i_ber_clear = 1'b1; i_enable = 1'b0; i_sample = 8'($urandom);
    i_ref_valid = 1'($urandom); i_ref_bit = 1'($urandom);
    tick();
    i_ber_clear = 1'b0;
    checks++; if (o_locked !== 1'b0 || o_delay !== '0) begin errors++;
      $display("FAIL clear_state got %0d@%0d want 0@0", o_locked, o_delay); end
    checks++; if (o_bit_count !== '0 || o_err_count !== '0) begin errors++;
      $display("FAIL clear_counts got %0d/%0d want 0/0", o_bit_count, o_err_count); end
    test_lock(1'b1);
  endtask

  task automatic test_relock();
    bit rb;
    link_delay = 40;
`ifdef BPSK_RX_RELOCK_EN
    begin
      int t0, drop_sym;
      bit dropped = 1'b0, relocked = 1'b0, held_ok = 1'b1;
      logic [NB_CNT-1:0] bc_drop, ec_drop;
      t0 = n_sym;
      while (!dropped && (n_sym - t0) < 4 * WIN_LEN) begin
        send_symbol(1'b0, 1'b0, rb);
        if (!o_locked) dropped = 1'b1;
      end
      drop_sym = n_sym; bc_drop = o_bit_count; ec_drop = o_err_count;
      checks++; if (!dropped) begin errors++; $display("FAIL relock_drop got 0 want 1"); end
      checks++; if (o_delay !== NB_DELAY'(38)) begin errors++; $display("FAIL relock_drop_delay got %0d want 38", o_delay); end
      checks++; if (bc_drop !== NB_CNT'(drop_sym - t0)) begin errors++;
        $display("FAIL relock_bitcnt got %0d want %0d", bc_drop, drop_sym - t0); end
      while (dropped && !relocked && (n_sym - drop_sym) < 5 * WIN_LEN) begin
        send_symbol(1'b0, 1'b0, rb);
        if (o_locked) relocked = 1'b1;
        else if (o_bit_count !== bc_drop || o_err_count !== ec_drop) held_ok = 1'b0;
      end
      checks++; if (!relocked) begin errors++; $display("FAIL relock_again got 0 want 1"); end
      checks++; if ((n_sym - drop_sym) != 3 * WIN_LEN) begin errors++;
        $display("FAIL relock_symbols got %0d want %0d", n_sym - drop_sym, 3 * WIN_LEN); end
      checks++; if (o_delay !== NB_DELAY'(40)) begin errors++; $display("FAIL relock_delay got %0d want 40", o_delay); end
      checks++; if (!held_ok) begin errors++; $display("FAIL relock_hold got changed want held"); end
    end
`else
    begin
      int e_exp = 0, ri, slot;
      for (int i = 0; i < 300; i++) begin
        slot = n_sym;
        send_symbol(1'b0, 1'b0, rb);
        ri = slot - 1 - 37;
        e_exp += int'(rb ^ ((ri >= 0) ? tx[ri] : 1'b0));
      end
      checks++; if (o_locked !== 1'b1 || o_delay !== NB_DELAY'(37)) begin errors++;
        $display("FAIL stay_locked got %0d@%0d want 1@37", o_locked, o_delay); end
      checks++; if (o_bit_count !== 64'd300) begin errors++; $display("FAIL stay_bitcnt got %0d want 300", o_bit_count); end
      checks++; if (o_err_count !== NB_CNT'(e_exp)) begin errors++; $display("FAIL stay_errcnt got %0d want %0d", o_err_count, e_exp); end
      checks++; if (e_exp < 90 || e_exp > 210) begin errors++; $display("FAIL stay_err_rate got %0d want 90..210", e_exp); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_phase();
    i_reset = 1'b1; tick(); i_reset = 1'b0; en_cnt = 0;
    i_phase_sel = 2'd0; link_delay = 37; n_sym = 0; lfsr = 9'h1ff;
    test_lock(1'b0);
    test_ber();
    test_enable_gaps();
    test_relock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
